// File: rtl/controller_pkg.sv
// controller_pkg: state encodings and default phase durations for the washer sequencer.
package controller_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDLE          = 3'd0;
   localparam state_t FILLING_WATER = 3'd1;
   localparam state_t WASHING       = 3'd2;
   localparam state_t RINSING       = 3'd3;
   localparam state_t SPINNING      = 3'd4;
   localparam int FILL_SEC_DEF  = 120;
   localparam int WASH_SEC_DEF  = 300;
   localparam int RINSE_SEC_DEF = 120;
   localparam int SPIN_SEC_DEF  = 60;
endpackage

// File: rtl/controller_sec_timer.sv
// controller_sec_timer: clk_freq-scaled prescaler producing a seconds tick and a per-state seconds count.
module controller_sec_timer #(
   parameter int TICKS_PER_SEC_1X = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] clk_freq,
   input  logic       en,
   input  logic       clr,
   output logic       tick_o,
   output logic [8:0] sec_o
);
   localparam int PW = $clog2(8 * TICKS_PER_SEC_1X);
   logic [PW-1:0] presc_q, presc_d;
   logic [8:0]    sec_q, sec_d;
   logic [31:0]   lim;
   // >= rather than == so a limit that shrinks mid-count still wraps
   always_comb begin
      lim     = (32'(TICKS_PER_SEC_1X) << clk_freq) - 32'd1;
      tick_o  = en && (32'(presc_q) >= lim);
      presc_d = clr ? '0 : !en ? presc_q : tick_o ? '0 : presc_q + 1'b1;
      sec_d   = clr ? '0 : sec_q + 9'(tick_o);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         sec_q   <= '0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
      end
   end
   assign sec_o = sec_q;
endmodule

// File: rtl/controller.sv
// controller: coin-operated washer sequencer (fill, wash, rinse, optional second wash/rinse, spin).
module controller
   import controller_pkg::*;
#(
   parameter int TICKS_PER_SEC_1X = 1,
   parameter int FILL_SEC         = FILL_SEC_DEF,
   parameter int WASH_SEC         = WASH_SEC_DEF,
   parameter int RINSE_SEC        = RINSE_SEC_DEF,
   parameter int SPIN_SEC         = SPIN_SEC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] clk_freq,
   input  logic       coin_in,
   input  logic       double_wash,
   input  logic       timer_pause,
   output logic       wash_done
);
   state_t      state_q, state_d;
   logic        flag_q, flag_d, done_q, done_d;
   logic        tick, en, clr, expired;
   logic [8:0]  sec;
   logic [31:0] dur;
   controller_sec_timer #(.TICKS_PER_SEC_1X(TICKS_PER_SEC_1X)) u_timer (
      .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .en(en), .clr(clr), .tick_o(tick), .sec_o(sec)
   );
   // expire on the tick that completes the last second, so each phase lasts exactly dur seconds
   always_comb begin
      dur = state_q == FILLING_WATER ? 32'(FILL_SEC) :
            state_q == WASHING       ? 32'(WASH_SEC) :
            state_q == RINSING       ? 32'(RINSE_SEC) : 32'(SPIN_SEC);
      expired = tick && ({23'd0, sec} + 32'd1 >= dur);
      state_d = state_q;
      flag_d  = flag_q;
      done_d  = done_q;
      case (state_q)
         IDLE: if (coin_in) begin
            state_d = FILLING_WATER;
            done_d  = 1'b0;
         end
         FILLING_WATER: if (expired) state_d = WASHING;
         WASHING:       if (expired) state_d = RINSING;
         RINSING: if (expired) begin
            flag_d  = flag_q | double_wash;
            state_d = (!flag_q && double_wash) ? WASHING : SPINNING;
         end
         SPINNING: if (expired) begin
            state_d = IDLE;
            done_d  = 1'b1;
            flag_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      en  = !(state_q == SPINNING && timer_pause);
      clr = (state_q == IDLE) || (state_d != state_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         flag_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         done_q  <= done_d;
      end
   end
   assign wash_done = done_q;
endmodule

// File: tb/tb_controller.sv
// tb_controller: table-driven job runs plus hand sequences for state order and mid-job reset.
module tb_controller;
   import controller_pkg::*;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [1:0] clk_freq = 2'b11;
   logic       coin_in = 1'b0, double_wash = 1'b0, timer_pause = 1'b0;
   logic       wash_done;
   int         tests = 0, fails = 0;
   state_t     seq[$];

   controller dut (
      .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .coin_in(coin_in),
      .double_wash(double_wash), .timer_pause(timer_pause), .wash_done(wash_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] f;
      logic       d;
      int         pa, pl, tlo, thi, clo, chi, exp;
   } vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_near(input string name, input int act, input int exp);
      tests++;
      if (act < exp - 2 || act > exp + 2) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (+/-2)", name, act, exp);
      end
   endtask

   // coin accepted at edge 0; returns the edge count at which wash_done rises (-1 on timeout)
   task automatic run_job(input vec_t v, output int el);
      state_t last;
      clk_freq    = v.f;
      double_wash = v.d;
      coin_in     = 1'b1;
      @(posedge clk); #1;
      coin_in = 1'b0;
      check({v.name, "_done_clr"}, int'(wash_done), 0);
      seq.delete();
      seq.push_back(dut.state_q);
      last = dut.state_q;
      el = -1;
      for (int c = 1; c < 12000; c++) begin
         timer_pause = (c > v.pa && c <= v.pa + v.pl);
         double_wash = (c > v.tlo && c <= v.thi) ? !v.d : v.d;
         coin_in     = (c > v.clo && c <= v.chi && (c % 16) < 4);
         @(posedge clk); #1;
         if (dut.state_q != last) begin
            seq.push_back(dut.state_q);
            last = dut.state_q;
         end
         if (wash_done) begin
            el = c;
            break;
         end
      end
      timer_pause = 1'b0;
      coin_in     = 1'b0;
      double_wash = 1'b0;
   endtask

   initial begin
      int     el;
      bit     ok;
      state_t exp_seq[7];
      vecs[0] = '{"dbl_8x",      2'b11, 1'b1, 0,    0,   0,    0,    0,    0,    8160};
      vecs[1] = '{"spin_pause",  2'b11, 1'b0, 4350, 240, 0,    0,    0,    0,    5040};
      vecs[2] = '{"fill_pause",  2'b11, 1'b1, 100,  240, 0,    0,    0,    0,    8160};
      vecs[3] = '{"freq00",      2'b00, 1'b0, 0,    0,   0,    0,    0,    0,    600};
      vecs[4] = '{"freq01",      2'b01, 1'b0, 0,    0,   0,    0,    0,    0,    1200};
      vecs[5] = '{"freq10",      2'b10, 1'b0, 0,    0,   0,    0,    0,    0,    2400};
      vecs[6] = '{"wash_pause",  2'b11, 1'b0, 1500, 240, 0,    0,    0,    0,    4800};
      vecs[7] = '{"coin_in_job", 2'b11, 1'b0, 0,    0,   0,    0,    1000, 2000, 4800};
      vecs[8] = '{"dbl_toggle",  2'b11, 1'b1, 0,    0,   7000, 7300, 0,    0,    8160};
      exp_seq = '{FILLING_WATER, WASHING, RINSING, WASHING, RINSING, SPINNING, IDLE};

      #23;
      check("rst_done", int'(wash_done), 0);
      check("rst_state", int'(dut.state_q), int'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_coin", int'(dut.state_q), int'(IDLE));

      foreach (vecs[i]) begin
         run_job(vecs[i], el);
         check_near({vecs[i].name, "_time"}, el, vecs[i].exp);
         if (i == 0) begin
            ok = (seq.size() == 7);
            for (int k = 0; k < 7 && ok; k++) ok = (seq[k] == exp_seq[k]);
            check("dbl_state_order", int'(ok), 1);
            check("dbl_seq_len", seq.size(), 7);
         end
         repeat (5) @(negedge clk);
      end

      // abort mid-RINSING with wash_done still high from the previous job
      check("done_held_idle", int'(wash_done), 1);
      clk_freq = 2'b11;
      coin_in  = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      repeat (3500) @(negedge clk);
      check("pre_abort_rinsing", int'(dut.state_q), int'(RINSING));
      #2 rst_n = 1'b0;
      #1;
      check("abort_state", int'(dut.state_q), int'(IDLE));
      check("abort_done", int'(wash_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5000) @(negedge clk);
      check("abort_no_resume", int'(wash_done), 0);
      check("abort_stays_idle", int'(dut.state_q), int'(IDLE));

      run_job(vecs[3], el);
      check_near("post_abort_time", el, 600);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
